// File: rtl/riscv_wb_arbiter_if.sv
// Bundle of the arbiter's requester, issue, decode and register-file port signals.
// The slave side is the arbiter; the master side is whatever drives the pipeline.
interface riscv_wb_arbiter_if;
  logic        a_valid_in;
  logic [4:0]  a_rd_in;
  logic [31:0] a_data_in;
  logic        a_ready_out;

  logic        b_valid_in;
  logic [4:0]  b_rd_in;
  logic [31:0] b_data_in;
  logic        b_ready_out;

  logic        issue_valid_in;
  logic [4:0]  issue_rd_in;

  logic [4:0]  ra_in;
  logic [4:0]  rb_in;
  logic        hazard_out;

  logic [31:0] pending_out;
  logic [5:0]  pending_count_out;

  logic        write_enable_out;
  logic [4:0]  rd_out;
  logic [31:0] wd_out;

  modport slave (
    input  a_valid_in, a_rd_in, a_data_in,
    output a_ready_out,
    input  b_valid_in, b_rd_in, b_data_in,
    output b_ready_out,
    input  issue_valid_in, issue_rd_in,
    input  ra_in, rb_in,
    output hazard_out,
    output pending_out, pending_count_out,
    output write_enable_out, rd_out, wd_out
  );

  modport master (
    output a_valid_in, a_rd_in, a_data_in,
    input  a_ready_out,
    output b_valid_in, b_rd_in, b_data_in,
    input  b_ready_out,
    output issue_valid_in, issue_rd_in,
    output ra_in, rb_in,
    input  hazard_out,
    input  pending_out, pending_count_out,
    input  write_enable_out, rd_out, wd_out
  );
endinterface

// File: rtl/riscv_wb_arbiter.sv
// Writeback arbiter: round-robin between an ALU (A) and a long-latency unit (B)
// onto one register-file write port, plus a pending-register scoreboard for decode.
module riscv_wb_arbiter (
  input  logic               clk_in,
  input  logic               rst_in,
  riscv_wb_arbiter_if.slave  bus
);

  localparam logic [0:0] GRANT_A = 1'b0;
  localparam logic [0:0] GRANT_B = 1'b1;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

  logic [0:0]  last_grant_q, last_grant_d;
  logic [31:0] pending_q, pending_d;
  logic [5:0]  count_q, count_d;
  logic        we_q, we_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wd_q, wd_d;

  logic        a_grant_s;
  logic        b_grant_s;
  logic        ra_pend_s;
  logic        rb_pend_s;

  // Grant selection; a grant is only ever given to a valid requester, so grant == transfer.
  always_comb begin
    a_grant_s = 1'b0;
    b_grant_s = 1'b0;
    if (rst_in) begin
      a_grant_s = 1'b0;
      b_grant_s = 1'b0;
    end else if (bus.a_valid_in && bus.b_valid_in) begin
      if (last_grant_q == GRANT_B) begin
        a_grant_s = 1'b1;
      end else begin
        b_grant_s = 1'b1;
      end
    end else if (bus.a_valid_in) begin
      a_grant_s = 1'b1;
    end else if (bus.b_valid_in) begin
      b_grant_s = 1'b1;
    end else begin
      a_grant_s = 1'b0;
      b_grant_s = 1'b0;
    end
  end

  // Register-file port next state; rd/wd only move on an actual write so they hold otherwise.
  always_comb begin
    last_grant_d = last_grant_q;
    we_d         = 1'b0;
    rd_d         = rd_q;
    wd_d         = wd_q;
    if (a_grant_s) begin
      last_grant_d = GRANT_A;
      if (bus.a_rd_in != 5'd0) begin
        we_d = 1'b1;
        rd_d = bus.a_rd_in;
        wd_d = bus.a_data_in;
      end else begin
        we_d = 1'b0;
      end
    end else if (b_grant_s) begin
      last_grant_d = GRANT_B;
      if (bus.b_rd_in != 5'd0) begin
        we_d = 1'b1;
        rd_d = bus.b_rd_in;
        wd_d = bus.b_data_in;
      end else begin
        we_d = 1'b0;
      end
    end else begin
      we_d = 1'b0;
    end
  end

  // Scoreboard next state: clear on B writeback first so a same-cycle issue re-sets the bit.
  always_comb begin
    pending_d = pending_q;
    if (b_grant_s) begin
      pending_d[bus.b_rd_in] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (!rst_in && bus.issue_valid_in) begin
      pending_d[bus.issue_rd_in] = 1'b1;
    end else begin
      pending_d[0] = 1'b0;
    end
    pending_d[0] = 1'b0;
    count_d      = popcount32(pending_d);
  end

  // Decode hazard looks only at the registered scoreboard.
  always_comb begin
    ra_pend_s = (bus.ra_in != 5'd0) && pending_q[bus.ra_in];
    rb_pend_s = (bus.rb_in != 5'd0) && pending_q[bus.rb_in];
  end

  // State registers with synchronous reset; last_grant resets to B so A wins first contention.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      last_grant_q <= GRANT_B;
      pending_q    <= 32'd0;
      count_q      <= 6'd0;
      we_q         <= 1'b0;
      rd_q         <= 5'd0;
      wd_q         <= 32'd0;
    end else begin
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      count_q      <= count_d;
      we_q         <= we_d;
      rd_q         <= rd_d;
      wd_q         <= wd_d;
    end
  end

  assign bus.a_ready_out       = a_grant_s;
  assign bus.b_ready_out       = b_grant_s;
  assign bus.hazard_out        = ra_pend_s | rb_pend_s;
  assign bus.pending_out       = pending_q;
  assign bus.pending_count_out = count_q;
  assign bus.write_enable_out  = we_q;
  assign bus.rd_out            = rd_q;
  assign bus.wd_out            = wd_q;

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Self-checking bench for riscv_wb_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a behavioural model.
module tb_riscv_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  riscv_wb_arbiter_if bus ();

  riscv_wb_arbiter dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  bit        m_init = 1'b0;
  bit [31:0] m_pend;
  int        m_last;
  bit        m_we;
  bit [4:0]  m_rd;
  bit [31:0] m_wd;
  bit        m_a_xfer = 1'b0;
  bit        m_b_xfer = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: compare at every negedge, then advance to what the next rising edge produces.
  always @(negedge clk) begin : model
    int win;
    int rdx;
    win = -1;
    if (!rst) begin
      if (bus.a_valid_in && bus.b_valid_in) win = 1 - m_last;
      else if (bus.a_valid_in) win = 0;
      else if (bus.b_valid_in) win = 1;
    end
    if (m_init) begin
      check("m_a_ready", bus.a_ready_out, (win == 0));
      check("m_b_ready", bus.b_ready_out, (win == 1));
      check("m_hazard", bus.hazard_out,
            ((bus.ra_in != 0) && m_pend[bus.ra_in]) || ((bus.rb_in != 0) && m_pend[bus.rb_in]));
      check("m_pending", bus.pending_out, m_pend);
      check("m_count", bus.pending_count_out, $countones(m_pend));
      check("m_we", bus.write_enable_out, m_we);
      check("m_rd", bus.rd_out, m_rd);
      check("m_wd", bus.wd_out, m_wd);
    end
    m_a_xfer = (win == 0);
    m_b_xfer = (win == 1);
    if (rst) begin
      m_pend = 32'd0;
      m_last = 1;
      m_we   = 1'b0;
      m_rd   = 5'd0;
      m_wd   = 32'd0;
      m_init = 1'b1;
    end else begin
      m_we = 1'b0;
      if (win >= 0) begin
        m_last = win;
        rdx = (win == 0) ? bus.a_rd_in : bus.b_rd_in;
        if (rdx != 0) begin
          m_we = 1'b1;
          m_rd = 5'(rdx);
          m_wd = (win == 0) ? bus.a_data_in : bus.b_data_in;
        end
      end
      if (win == 1) m_pend[bus.b_rd_in] = 1'b0;
      if (bus.issue_valid_in && bus.issue_rd_in != 0) m_pend[bus.issue_rd_in] = 1'b1;
    end
  end

  task automatic to_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    bus.a_valid_in = 1'b1; bus.a_rd_in = 5'd0; bus.a_data_in = 32'd0;
    bus.b_valid_in = 1'b1; bus.b_rd_in = 5'd0; bus.b_data_in = 32'd0;
    bus.issue_valid_in = 1'b1; bus.issue_rd_in = 5'd12;
    bus.ra_in = 5'd0; bus.rb_in = 5'd0;
    rst = 1'b1;

    // Reset state, with both requesters and an issue active
    to_neg();
    check("rst_a_ready", bus.a_ready_out, 32'd0);
    check("rst_b_ready", bus.b_ready_out, 32'd0);
    to_pos();
    to_neg();
    check("rst_pending", bus.pending_out, 32'd0);
    check("rst_count", bus.pending_count_out, 32'd0);
    check("rst_we", bus.write_enable_out, 32'd0);
    check("rst_rd", bus.rd_out, 32'd0);
    check("rst_wd", bus.wd_out, 32'd0);
    to_pos();

    // Single A write
    rst = 1'b0;
    bus.issue_valid_in = 1'b0;
    bus.b_valid_in = 1'b0;
    bus.a_valid_in = 1'b1; bus.a_rd_in = 5'd5; bus.a_data_in = 32'hDEADBEEF;
    to_neg();
    check("a1_ready", bus.a_ready_out, 32'd1);
    to_pos();
    bus.a_valid_in = 1'b0;
    to_neg();
    check("a1_we", bus.write_enable_out, 32'd1);
    check("a1_rd", bus.rd_out, 32'd5);
    check("a1_wd", bus.wd_out, 32'hDEADBEEF);
    to_pos();
    to_neg();
    check("a1_we_off", bus.write_enable_out, 32'd0);
    check("a1_rd_hold", bus.rd_out, 32'd5);
    to_pos();

    // Round-robin under continuous contention right after reset
    rst = 1'b1;
    to_pos();
    rst = 1'b0;
    bus.a_valid_in = 1'b1; bus.a_rd_in = 5'd3; bus.a_data_in = 32'h0000_0333;
    bus.b_valid_in = 1'b1; bus.b_rd_in = 5'd4; bus.b_data_in = 32'h0000_0444;
    for (int i = 0; i < 4; i++) begin
      to_neg();
      check("rr_a_ready", bus.a_ready_out, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_b_ready", bus.b_ready_out, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i > 0) check("rr_rd", bus.rd_out, (i % 2 == 1) ? 32'd3 : 32'd4);
      to_pos();
    end
    bus.a_valid_in = 1'b0;
    bus.b_valid_in = 1'b0;
    to_neg();
    check("rr_rd_last", bus.rd_out, 32'd4);
    check("rr_wd_last", bus.wd_out, 32'h0000_0444);
    to_pos();

    // Scoreboard set / hazard / clear
    bus.issue_valid_in = 1'b1; bus.issue_rd_in = 5'd7; bus.ra_in = 5'd7;
    to_neg();
    check("sb_hazard_issue", bus.hazard_out, 32'd0);
    to_pos();
    bus.issue_valid_in = 1'b0;
    to_neg();
    check("sb_hazard_set", bus.hazard_out, 32'd1);
    check("sb_count1", bus.pending_count_out, 32'd1);
    to_pos();
    bus.b_valid_in = 1'b1; bus.b_rd_in = 5'd7; bus.b_data_in = 32'h0000_0777;
    to_neg();
    check("sb_b_ready", bus.b_ready_out, 32'd1);
    check("sb_hazard_nobypass", bus.hazard_out, 32'd1);
    to_pos();
    bus.b_valid_in = 1'b0;
    to_neg();
    check("sb_hazard_clr", bus.hazard_out, 32'd0);
    check("sb_count0", bus.pending_count_out, 32'd0);
    to_pos();
    bus.ra_in = 5'd0;

    // Same-cycle issue and clear of one register: the issue wins
    bus.issue_valid_in = 1'b1; bus.issue_rd_in = 5'd9;
    to_pos();
    bus.b_valid_in = 1'b1; bus.b_rd_in = 5'd9; bus.b_data_in = 32'h0000_0999;
    to_neg();
    check("sc_pend_before", bus.pending_out, 32'h0000_0200);
    to_pos();
    bus.issue_valid_in = 1'b0;
    to_neg();
    check("sc_pend_kept", bus.pending_out, 32'h0000_0200);
    check("sc_count_kept", bus.pending_count_out, 32'd1);
    to_pos();

    // x0 issue and x0 writeback
    bus.b_valid_in = 1'b0;
    bus.issue_valid_in = 1'b1; bus.issue_rd_in = 5'd0;
    to_neg();
    check("x0_pend_clr", bus.pending_out, 32'd0);
    check("x0_rd9", bus.rd_out, 32'd9);
    to_pos();
    bus.issue_valid_in = 1'b0;
    bus.a_valid_in = 1'b1; bus.a_rd_in = 5'd0; bus.a_data_in = 32'h1234_5678;
    to_neg();
    check("x0_pend_issue", bus.pending_out, 32'd0);
    check("x0_a_ready", bus.a_ready_out, 32'd1);
    to_pos();
    bus.a_valid_in = 1'b0;
    to_neg();
    check("x0_we", bus.write_enable_out, 32'd0);
    check("x0_rd_hold", bus.rd_out, 32'd9);
    check("x0_wd_hold", bus.wd_out, 32'h0000_0999);
    to_pos();

    // Reset mid-operation with pending registers and both requesters valid
    bus.issue_valid_in = 1'b1; bus.issue_rd_in = 5'd1;
    to_pos();
    bus.issue_rd_in = 5'd2;
    to_pos();
    bus.issue_rd_in = 5'd3;
    to_pos();
    bus.issue_valid_in = 1'b0;
    to_neg();
    check("mr_count3", bus.pending_count_out, 32'd3);
    check("mr_pend3", bus.pending_out, 32'h0000_000E);
    to_pos();
    bus.a_valid_in = 1'b1; bus.a_rd_in = 5'd10; bus.a_data_in = 32'h0000_0AAA;
    bus.b_valid_in = 1'b1; bus.b_rd_in = 5'd11; bus.b_data_in = 32'h0000_0BBB;
    rst = 1'b1;
    to_neg();
    check("mr_a_ready_rst", bus.a_ready_out, 32'd0);
    check("mr_b_ready_rst", bus.b_ready_out, 32'd0);
    to_pos();
    rst = 1'b0;
    to_neg();
    check("mr_pend", bus.pending_out, 32'd0);
    check("mr_count", bus.pending_count_out, 32'd0);
    check("mr_we", bus.write_enable_out, 32'd0);
    check("mr_a_first", bus.a_ready_out, 32'd1);
    check("mr_b_first", bus.b_ready_out, 32'd0);
    to_pos();

    // Randomized traffic; requesters hold rd/data until accepted
    for (int n = 0; n < 3000; n++) begin
      if (!(bus.a_valid_in && !m_a_xfer)) begin
        bus.a_valid_in = ($urandom_range(0, 9) < 6);
        bus.a_rd_in    = 5'($urandom_range(0, 15));
        bus.a_data_in  = $urandom;
      end
      if (!(bus.b_valid_in && !m_b_xfer)) begin
        bus.b_valid_in = ($urandom_range(0, 9) < 5);
        bus.b_rd_in    = 5'($urandom_range(0, 15));
        bus.b_data_in  = $urandom;
      end
      bus.issue_valid_in = ($urandom_range(0, 9) < 4);
      bus.issue_rd_in    = 5'($urandom_range(0, 15));
      bus.ra_in          = 5'($urandom_range(0, 15));
      bus.rb_in          = 5'($urandom_range(0, 31));
      rst = ($urandom_range(0, 199) == 0);
      to_pos();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
